// File: rtl/pool_result_reader.sv
// Pool RAM read-back streamer: reads every pool word in address order after start,
// buffered in a 2-entry FIFO on a valid/ready stream. Optional checksum: POOL_RD_CHECKSUM_EN.
module pool_result_reader #(
   parameter int unsigned ADDR_BITS = 16,
   parameter int unsigned DATA_BITS = 16,
   parameter int unsigned NUM_WORDS = 16384
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [ADDR_BITS-1:0] RAM_POOL_A,
   output logic                 RAM_POOL_OE,
   input  logic [DATA_BITS-1:0] RAM_POOL_Q,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 busy,
`ifdef POOL_RD_CHECKSUM_EN
   output logic [DATA_BITS-1:0] checksum,
`endif
   output logic                 rd_done
);

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_WORDS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

   state_t               state, state_nxt;
   logic                 start_q;
   logic                 start_edge;
   logic [ADDR_BITS-1:0] rd_addr;
   logic [ADDR_BITS-1:0] a_q;
   logic                 inflight;
   logic                 inflight_last;
   logic [DATA_BITS-1:0] fifo_data [2];
   logic [1:0]           fifo_last;
   logic                 wr_ptr, rd_ptr;
   logic [1:0]           fifo_cnt;
   logic                 issue_c, pop_c, push_c;

   assign start_edge = start & ~start_q;
   assign pop_c      = out_valid & out_ready;
   assign push_c     = inflight;

   // Issue only if the word can be buffered even when no pop follows
   assign issue_c = (state == FETCH) &&
                    ((3'(fifo_cnt) + 3'(inflight)) < (3'd2 + 3'(pop_c)));

   assign RAM_POOL_OE = issue_c;
   assign RAM_POOL_A  = issue_c ? rd_addr : a_q;

   assign out_valid = (fifo_cnt != 2'd0);
   assign out_data  = fifo_data[rd_ptr];
   assign out_last  = out_valid & fifo_last[rd_ptr];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start_edge) state_nxt = FETCH;
         FETCH: if (issue_c && (rd_addr == LAST_ADDR)) state_nxt = DRAIN;
         DRAIN: if (pop_c && out_last) state_nxt = FIN;
         FIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Address counter, read pipeline, FIFO and status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_q       <= 1'b0;
         rd_addr       <= '0;
         a_q           <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         fifo_data[0]  <= '0;
         fifo_data[1]  <= '0;
         fifo_last     <= '0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         fifo_cnt      <= '0;
         busy          <= 1'b0;
         rd_done       <= 1'b0;
      end else begin
         start_q       <= start;
         busy          <= (state_nxt == FETCH) || (state_nxt == DRAIN);
         rd_done       <= (state_nxt == FIN);
         inflight      <= issue_c;
         inflight_last <= issue_c && (rd_addr == LAST_ADDR);

         if (state == IDLE)
            rd_addr <= '0;
         else if (issue_c && (rd_addr != LAST_ADDR))
            rd_addr <= rd_addr + ADDR_BITS'(1);

         if (issue_c)
            a_q <= rd_addr;
         else if (state == FIN)
            a_q <= '0;

         if (push_c) begin
            fifo_data[wr_ptr] <= RAM_POOL_Q;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop_c)
            rd_ptr <= ~rd_ptr;
         fifo_cnt <= 2'(fifo_cnt + 2'(push_c) - 2'(pop_c));
      end
   end

`ifdef POOL_RD_CHECKSUM_EN
   // Wrapping sum of accepted words, cleared on the accepted start edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         checksum <= '0;
      else if ((state == IDLE) && start_edge)
         checksum <= '0;
      else if (pop_c)
         checksum <= checksum + out_data;
   end
`endif

endmodule

// File: tb/tb_pool_result_reader.sv
// Bench for pool_result_reader: reset, full stream, stall, backpressure, retrigger;
// checksum checked when POOL_RD_CHECKSUM_EN is defined.
module tb_pool_result_reader;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned N  = 16384;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] RAM_POOL_A;
   logic          RAM_POOL_OE;
   logic [DW-1:0] RAM_POOL_Q = '0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
   logic          rd_done;
`ifdef POOL_RD_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   pool_result_reader #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_WORDS(N)) dut (
      .clk(clk), .rst(rst), .start(start),
      .RAM_POOL_A(RAM_POOL_A), .RAM_POOL_OE(RAM_POOL_OE), .RAM_POOL_Q(RAM_POOL_Q),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy),
`ifdef POOL_RD_CHECKSUM_EN
      .checksum(checksum),
`endif
      .rd_done(rd_done)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [N];

   // Synchronous-read RAM: data appears the cycle after OE
   always @(posedge clk) if (RAM_POOL_OE) RAM_POOL_Q <= mem[RAM_POOL_A];

   int       n_assert = 0;
   int       n_fail   = 0;
   // Reference model: counts of reads issued / words accepted, plus phase of the run
   int       issued, accepted, issued_lag, phase;
   logic     start_prev;
   logic [DW-1:0] sum_exp;
   int       oe_seen, done_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      issued = 0; accepted = 0; issued_lag = 0; phase = 0;
      start_prev = 1'b0; sum_exp = '0;
   endtask

   // One clock cycle: check at negedge against the model, advance model, return at posedge+1
   task automatic tick();
      logic exp_valid, pop, exp_oe;
      int   exp_a;
      @(negedge clk);
      exp_valid = (issued_lag > accepted);
      pop       = exp_valid && out_ready;
      exp_oe    = (phase == 1) && (issued < int'(N)) &&
                  ((issued - accepted - (pop ? 1 : 0)) < 2);
      if (phase == 0)  exp_a = 0;
      else if (exp_oe) exp_a = issued;
      else             exp_a = (issued == 0) ? 0 : issued - 1;

      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) chk("out_data", 32'(out_data), 32'(mem[accepted]));
      chk("out_last", 32'(out_last), 32'(exp_valid && (accepted == int'(N) - 1)));
      chk("ram_oe", 32'(RAM_POOL_OE), 32'(exp_oe));
      chk("ram_a", 32'(RAM_POOL_A), 32'(exp_a));
      chk("busy", 32'(busy), 32'(phase == 1));
      chk("rd_done", 32'(rd_done), 32'(phase == 2));
`ifdef POOL_RD_CHECKSUM_EN
      if (phase == 2) chk("checksum", 32'(checksum), 32'(sum_exp));
`endif
      if (RAM_POOL_OE) oe_seen++;
      if (rd_done) done_seen++;

      issued_lag = issued;
      if (exp_oe) issued++;
      if (pop) begin
         sum_exp = sum_exp + mem[accepted];
         accepted++;
      end
      if (phase == 2) phase = 0;
      else if (phase == 1 && pop && accepted == int'(N)) phase = 2;
      else if (phase == 0 && start && !start_prev) begin
         phase = 1; issued = 0; accepted = 0; issued_lag = 0; sum_exp = '0;
      end
      start_prev = start;
      @(posedge clk);
      #1;
   endtask

   // Runs until the model sees a completed pass; out_ready high with probability pct%
   task automatic run_pass(input int pct, input int budget);
      int   n = 0;
      logic fin_seen = 1'b0;
      while (!(fin_seen && phase == 0) && n < budget) begin
         out_ready = ($urandom_range(99) < pct);
         tick();
         if (phase == 2) fin_seen = 1'b1;
         n++;
      end
      chk("pass_complete", 32'(fin_seen && phase == 0), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < int'(N); i++) mem[i] = DW'(i);
      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      model_reset();
      oe_seen = 0; done_seen = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_oe", 32'(RAM_POOL_OE), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      repeat (3) tick();

      // Reset while fetching: outputs clear asynchronously, no rd_done afterwards
      start = 1'b1; out_ready = 1'b1;
      repeat (6) tick();
      #2 rst = 1'b1;
      #1;
      chk("rst_a", 32'(RAM_POOL_A), 32'd0);
      chk("rst_oe_mid", 32'(RAM_POOL_OE), 32'd0);
      chk("rst_valid_mid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(rd_done), 32'd0);
`ifdef POOL_RD_CHECKSUM_EN
      chk("rst_checksum", 32'(checksum), 32'd0);
`endif
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      done_seen = 0;
      repeat (5) tick();
      chk("no_done_after_rst", 32'(done_seen), 32'd0);

      // Full stream with ready high; start held high afterwards must not rerun
      start = 1'b1;
      run_pass(100, 20000);
      out_ready = 1'b1;
      repeat (20) tick();
      chk("single_pass", 32'(done_seen), 32'd1);
`ifdef POOL_RD_CHECKSUM_EN
      chk("checksum_spec", 32'(checksum), 32'((N * (N - 1) / 2) & 32'hFFFF));
`endif

      // Retrigger with a stalled sink: exactly two reads until the first pop
      start = 1'b0;
      repeat (3) tick();
      start = 1'b1; out_ready = 1'b0; oe_seen = 0;
      repeat (11) tick();
      chk("stall_reads", 32'(oe_seen), 32'd2);
      chk("stall_valid", 32'(out_valid), 32'd1);

      // Continue under random backpressure (ready 70%)
      run_pass(70, 60000);
      repeat (5) tick();
      chk("second_pass", 32'(done_seen), 32'd2);
`ifdef POOL_RD_CHECKSUM_EN
      chk("checksum_spec2", 32'(checksum), 32'((N * (N - 1) / 2) & 32'hFFFF));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
